// File: rtl/fetch_ctrl.sv
// fetch_ctrl: boot-loader / fetch-enable controller.
// Sequences IDLE -> LOAD (loader writes into IMEM) -> RUN (fetch enabled)
// <-> HALTED, keeps saturating fetch/load counters and a sticky flag for
// loader writes attempted after boot.
// Optional build macro FETCH_WATCHDOG_EN adds a stall watchdog that forces
// HALTED after 255 consecutive stalled RUN cycles and raises wdog_timeout.

`ifndef PC_WIDTH
`define PC_WIDTH 8
`endif

module fetch_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 boot_wr_valid,
  input  logic [`PC_WIDTH-1:0] boot_wr_addr,
  input  logic [15:0]          boot_wr_data,
  output logic                 boot_wr_ready,
  input  logic                 boot_done,
  input  logic                 stall_req,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic                 imem_we,
  output logic [`PC_WIDTH-1:0] imem_waddr,
  output logic [15:0]          imem_wdata,
  output logic                 instruction_fetch_en,
  output logic [1:0]           state,
  output logic [15:0]          fetch_count,
  output logic [15:0]          load_count,
  output logic                 boot_err,
  output logic                 wdog_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state_q;
  logic   wr_accept;
  logic   wr_illegal;
  logic   wdog_fire;

  assign state = state_q;

  // Loader handshake: only IDLE and LOAD accept writes. Reset forces
  // state_q to IDLE asynchronously, so ready reads 1 during reset while the
  // write strobe is gated off explicitly.
  assign boot_wr_ready = (state_q == IDLE) || (state_q == LOAD);
  assign wr_accept     = boot_wr_valid && boot_wr_ready && !rst;
  assign wr_illegal    = boot_wr_valid && !boot_wr_ready;

  assign imem_we    = wr_accept;
  assign imem_waddr = boot_wr_addr;
  assign imem_wdata = boot_wr_data;

  // Fetch advances only when running and nobody is holding or stopping it;
  // halt_req blocks fetch in the same cycle it is raised.
  assign instruction_fetch_en = (state_q == RUN) && !stall_req && !halt_req && !rst;

`ifdef FETCH_WATCHDOG_EN
  logic [7:0] wdog_cnt;
  logic       wdog_q;

  // The cycle whose stall would bring the streak to 255 is the firing cycle;
  // the FSM lands in HALTED on the following edge.
  assign wdog_fire    = (state_q == RUN) && stall_req && (wdog_cnt == 8'd254);
  assign wdog_timeout = wdog_q;

  // Streak of consecutive stalled RUN cycles plus the sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= 8'd0;
      wdog_q   <= 1'b0;
    end else begin
      if (wdog_fire || (state_q != RUN) || !stall_req) begin
        wdog_cnt <= 8'd0;
      end else begin
        wdog_cnt <= wdog_cnt + 8'd1;
      end
      if (wdog_fire) begin
        wdog_q <= 1'b1;
      end
    end
  end
`else
  assign wdog_fire    = 1'b0;
  assign wdog_timeout = 1'b0;
`endif

  // Control FSM and sticky illegal-write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      boot_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // in the block samples pre-edge values, matching real flip-flops.
      if (wr_illegal) begin
        boot_err <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (boot_done) begin
            state_q <= RUN;
          end else if (boot_wr_valid) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (boot_done) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (halt_req || wdog_fire) begin
            state_q <= HALTED;
          end
        end
        HALTED: begin
          if (resume && !halt_req) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles in which the fetch stage advanced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 16'd0;
    end else if (instruction_fetch_en && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end

  // Saturating count of loader writes that reached IMEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count <= 16'd0;
    end else if (wr_accept && (load_count != 16'hFFFF)) begin
      load_count <= load_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic for fetch_ctrl,
// each checked against a cycle-level behavioural model of the block.

`ifndef PC_WIDTH
`define PC_WIDTH 8
`endif

module tb_fetch_ctrl;

  localparam int AW = `PC_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot_wr_valid;
  logic [AW-1:0] boot_wr_addr;
  logic [15:0]   boot_wr_data;
  logic          boot_wr_ready;
  logic          boot_done;
  logic          stall_req;
  logic          halt_req;
  logic          resume;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [15:0]   imem_wdata;
  logic          instruction_fetch_en;
  logic [1:0]    state;
  logic [15:0]   fetch_count;
  logic [15:0]   load_count;
  logic          boot_err;
  logic          wdog_timeout;

  int total = 0;
  int bad   = 0;

  // Behavioural model: state as a plain number (0 idle, 1 load, 2 run,
  // 3 halted), counters as ints, streak of stalled run cycles.
  int m_state, m_fetch, m_load, m_streak;
  bit m_err, m_wdog;

  fetch_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .boot_wr_valid        (boot_wr_valid),
    .boot_wr_addr         (boot_wr_addr),
    .boot_wr_data         (boot_wr_data),
    .boot_wr_ready        (boot_wr_ready),
    .boot_done            (boot_done),
    .stall_req            (stall_req),
    .halt_req             (halt_req),
    .resume               (resume),
    .imem_we              (imem_we),
    .imem_waddr           (imem_waddr),
    .imem_wdata           (imem_wdata),
    .instruction_fetch_en (instruction_fetch_en),
    .state                (state),
    .fetch_count          (fetch_count),
    .load_count           (load_count),
    .boot_err             (boot_err),
    .wdog_timeout         (wdog_timeout)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    boot_wr_valid = 1'b0;
    boot_wr_addr  = '0;
    boot_wr_data  = 16'h0;
    boot_done     = 1'b0;
    stall_req     = 1'b0;
    halt_req      = 1'b0;
    resume        = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0; m_fetch = 0; m_load = 0; m_streak = 0;
    m_err = 1'b0; m_wdog = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit fire;
    fire = 1'b0;
    if (boot_wr_valid && m_state < 2 && m_load < 65535) m_load++;
    if (m_state == 2 && !stall_req && !halt_req && m_fetch < 65535) m_fetch++;
    if (boot_wr_valid && m_state >= 2) m_err = 1'b1;
`ifdef FETCH_WATCHDOG_EN
    if (m_state == 2 && stall_req) m_streak++;
    else m_streak = 0;
    if (m_streak == 255) begin
      fire = 1'b1; m_streak = 0; m_wdog = 1'b1;
    end
`endif
    case (m_state)
      0: if (boot_done) m_state = 2; else if (boot_wr_valid) m_state = 1;
      1: if (boot_done) m_state = 2;
      2: if (halt_req || fire) m_state = 3;
      default: if (resume && !halt_req) m_state = 2;
    endcase
  endtask

  // One clock: model follows the edge, outputs settle 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    boot_wr_valid = 1'b1;
    boot_wr_addr  = AW'($urandom);
    boot_done     = 1'b1;
    @(posedge clk); #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL reset_fetch_count: got %0d want 0", fetch_count); end
    total++; if (load_count !== 16'd0) begin bad++; $display("FAIL reset_load_count: got %0d want 0", load_count); end
    total++; if (boot_err !== 1'b0) begin bad++; $display("FAIL reset_boot_err: got %b want 0", boot_err); end
    total++; if (wdog_timeout !== 1'b0) begin bad++; $display("FAIL reset_wdog: got %b want 0", wdog_timeout); end
    total++; if (instruction_fetch_en !== 1'b0) begin bad++; $display("FAIL reset_fetch_en: got %b want 0", instruction_fetch_en); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
    total++; if (boot_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", boot_wr_ready); end
    clear_inputs();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_load_run();
    logic [15:0] words [3];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      boot_wr_valid = 1'b1;
      boot_wr_addr  = AW'(i);
      boot_wr_data  = words[i];
      #1;
      total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL load_we[%0d]: got %b want 1", i, imem_we); end
      total++; if (imem_waddr !== AW'(i)) begin bad++; $display("FAIL load_addr[%0d]: got %0d want %0d", i, imem_waddr, i); end
      total++; if (imem_wdata !== words[i]) begin bad++; $display("FAIL load_data[%0d]: got %h want %h", i, imem_wdata, words[i]); end
      tick();
    end
    clear_inputs();
    boot_done = 1'b1;
    #1;
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL load_we_idle: got %b want 0", imem_we); end
    tick();
    clear_inputs();
    #1;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL load_state_run: got %0d want 2", state); end
    total++; if (load_count !== 16'd3) begin bad++; $display("FAIL load_count: got %0d want 3", load_count); end
  endtask

  task automatic test_stall();
    bit pat [10];
    int placed, start;
    placed = 0;
    for (int i = 0; i < 10; i++) pat[i] = 1'b0;
    while (placed < 4) begin
      int p;
      p = $urandom_range(9);
      if (!pat[p]) begin pat[p] = 1'b1; placed++; end
    end
    start = m_fetch;
    for (int i = 0; i < 10; i++) begin
      stall_req = pat[i];
      #1;
      total++; if (instruction_fetch_en !== !pat[i]) begin bad++; $display("FAIL stall_fetch_en[%0d]: got %b want %b", i, instruction_fetch_en, !pat[i]); end
      tick();
    end
    stall_req = 1'b0;
    #1;
    total++; if (fetch_count !== 16'(start + 6)) begin bad++; $display("FAIL stall_fetch_count: got %0d want %0d", fetch_count, start + 6); end
  endtask

  task automatic test_boot_err();
    boot_wr_valid = 1'b1;
    boot_wr_addr  = AW'($urandom);
    boot_wr_data  = 16'($urandom);
    #1;
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL err_imem_we: got %b want 0", imem_we); end
    total++; if (boot_wr_ready !== 1'b0) begin bad++; $display("FAIL err_ready: got %b want 0", boot_wr_ready); end
    total++; if (boot_err !== 1'b0) begin bad++; $display("FAIL err_early: got %b want 0", boot_err); end
    tick();
    boot_wr_valid = 1'b0;
    #1;
    total++; if (boot_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", boot_err); end
    for (int i = 0; i < 3; i++) tick();
    total++; if (boot_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", boot_err); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL err_state: got %0d want 2", state); end
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    #1;
    total++; if (instruction_fetch_en !== 1'b0) begin bad++; $display("FAIL halt_fetch_en_same: got %b want 0", instruction_fetch_en); end
    tick();
    halt_req = 1'b0;
    #1;
    total++; if (state !== 2'd3) begin bad++; $display("FAIL halt_state: got %0d want 3", state); end
    total++; if (instruction_fetch_en !== 1'b0) begin bad++; $display("FAIL halt_fetch_en: got %b want 0", instruction_fetch_en); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL resume_state: got %0d want 2", state); end
    total++; if (instruction_fetch_en !== 1'b1) begin bad++; $display("FAIL resume_fetch_en: got %b want 1", instruction_fetch_en); end
    halt_req = 1'b1;
    tick();
    resume = 1'b1;
    tick();
    halt_req = 1'b0; resume = 1'b0;
    #1;
    total++; if (state !== 2'd3) begin bad++; $display("FAIL halt_resume_both: got %0d want 3", state); end
  endtask

  task automatic test_write_with_done();
    apply_reset();
    boot_wr_valid = 1'b1;
    boot_wr_addr  = AW'($urandom);
    boot_wr_data  = 16'($urandom);
    boot_done     = 1'b1;
    #1;
    total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL wd_imem_we: got %b want 1", imem_we); end
    tick();
    clear_inputs();
    #1;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL wd_state: got %0d want 2", state); end
    total++; if (load_count !== 16'd1) begin bad++; $display("FAIL wd_load_count: got %0d want 1", load_count); end
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      boot_wr_valid = 1'b1;
      boot_wr_addr  = AW'(i + 8);
      boot_wr_data  = 16'($urandom);
      tick();
    end
    total++; if (state !== 2'd1 || load_count !== 16'd2) begin bad++; $display("FAIL mid_pre: got state %0d count %0d want 1/2", state, load_count); end
    rst = 1'b1;
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL mid_state: got %0d want 0", state); end
    total++; if (load_count !== 16'd0) begin bad++; $display("FAIL mid_load_count: got %0d want 0", load_count); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL mid_imem_we: got %b want 0", imem_we); end
    @(posedge clk); #1;
    total++; if (imem_we !== 1'b0 || load_count !== 16'd0) begin bad++; $display("FAIL mid_hold: got we %b count %0d want 0/0", imem_we, load_count); end
    clear_inputs();
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      apply_reset();
      for (int cyc = 0; cyc < 300; cyc++) begin
        bit exp_we;
        boot_wr_valid = ($urandom_range(99) < 30);
        boot_wr_addr  = AW'($urandom);
        boot_wr_data  = 16'($urandom);
        boot_done     = ($urandom_range(99) < 5);
        stall_req     = ($urandom_range(99) < 30);
        halt_req      = ($urandom_range(99) < 10);
        resume        = ($urandom_range(99) < 25);
        exp_we = boot_wr_valid && (m_state < 2);
        #1;
        total++; if (boot_wr_ready !== (m_state < 2)) begin bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, boot_wr_ready, m_state < 2); end
        total++; if (imem_we !== exp_we) begin bad++; $display("FAIL rnd_we c%0d: got %b want %b", cyc, imem_we, exp_we); end
        if (exp_we) begin
          total++; if (imem_waddr !== boot_wr_addr || imem_wdata !== boot_wr_data) begin bad++; $display("FAIL rnd_wpayload c%0d: got %h/%h want %h/%h", cyc, imem_waddr, imem_wdata, boot_wr_addr, boot_wr_data); end
        end
        total++; if (instruction_fetch_en !== (m_state == 2 && !stall_req && !halt_req)) begin bad++; $display("FAIL rnd_fetch_en c%0d: got %b", cyc, instruction_fetch_en); end
        tick();
        total++; if (state !== 2'(m_state)) begin bad++; $display("FAIL rnd_state c%0d: got %0d want %0d", cyc, state, m_state); end
        total++; if (fetch_count !== 16'(m_fetch) || load_count !== 16'(m_load)) begin bad++; $display("FAIL rnd_counts c%0d: got %0d/%0d want %0d/%0d", cyc, fetch_count, load_count, m_fetch, m_load); end
        total++; if (boot_err !== m_err || wdog_timeout !== m_wdog) begin bad++; $display("FAIL rnd_flags c%0d: got %b/%b want %b/%b", cyc, boot_err, wdog_timeout, m_err, m_wdog); end
      end
    end
    clear_inputs();
  endtask

`ifdef FETCH_WATCHDOG_EN
  task automatic test_watchdog();
    apply_reset();
    boot_done = 1'b1;
    tick();
    clear_inputs();
    stall_req = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    stall_req = 1'b0;
    tick();
    total++; if (state !== 2'd2 || wdog_timeout !== 1'b0) begin bad++; $display("FAIL wdog_254: got state %0d to %b want 2/0", state, wdog_timeout); end
    stall_req = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL wdog_early: got %0d want 2", state); end
    tick();
    stall_req = 1'b0;
    #1;
    total++; if (state !== 2'd3) begin bad++; $display("FAIL wdog_state: got %0d want 3", state); end
    total++; if (wdog_timeout !== 1'b1) begin bad++; $display("FAIL wdog_flag: got %b want 1", wdog_timeout); end
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #2;
    test_reset();
    test_load_run();
    test_stall();
    test_boot_err();
    test_halt();
    test_write_with_done();
    test_reset_mid_load();
    test_random();
`ifdef FETCH_WATCHDOG_EN
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port boot_wr_valid, input, 1, loader write request.
REQ-004 SHALL have port boot_wr_addr, input, `PC_WIDTH, IMEM word address for the loader write.
REQ-005 SHALL have port boot_wr_data, input, 16, instruction word for the loader write.
REQ-006 SHALL have port boot_wr_ready, output, 1, loader write accepted this cycle.
REQ-007 SHALL have port boot_done, input, 1, loader finished; start execution.
REQ-008 SHALL have port stall_req, input, 1, hazard unit requests fetch hold.
REQ-009 SHALL have port halt_req, input, 1, stop fetching.
REQ-010 SHALL have port resume, input, 1, restart fetching from HALTED.
REQ-011 SHALL have port imem_we, output, 1, IMEM write strobe.
REQ-012 SHALL have port imem_waddr / imem_wdata, output, `PC_WIDTH / 16, IMEM write address and data.
REQ-013 SHALL have port instruction_fetch_en, output, 1, drives the fetch stage PC-advance enable.
REQ-014 SHALL have port state, output, 2, current FSM state encoding.
REQ-015 SHALL have port fetch_count, output, 16, number of cycles with instruction_fetch_en=1.
REQ-016 SHALL have port load_count, output, 16, number of accepted loader writes.
REQ-017 SHALL have port boot_err, output, 1, sticky flag: loader write attempted outside IDLE/LOAD.
REQ-018 SHALL have port wdog_timeout, output, 1, watchdog fired (see Configuration).

Function
REQ-019 SHALL implement states IDLE=0, LOAD=1, RUN=2, HALTED=3.
REQ-020 IDLE: boot_done -> RUN; else boot_wr_valid -> LOAD; boot_done has priority over boot_wr_valid.
REQ-021 LOAD: boot_done -> RUN; otherwise remain in LOAD.
REQ-022 RUN: halt_req -> HALTED; else remain in RUN.
REQ-023 HALTED: resume -> RUN; halt_req and resume together -> stay HALTED.
REQ-024 boot_wr_ready SHALL be combinationally 1 in IDLE and LOAD, 0 in RUN and HALTED.
REQ-025 A write is accepted when boot_wr_valid && boot_wr_ready; on acceptance imem_we=1 that cycle (combinational), imem_waddr/imem_wdata = boot_wr_addr/boot_wr_data; otherwise imem_we=0.
REQ-026 A write presented together with boot_done in IDLE/LOAD SHALL still be accepted, then the FSM enters RUN.
REQ-027 instruction_fetch_en SHALL be combinationally (state==RUN) && !stall_req && !halt_req.
REQ-028 fetch_count SHALL increment by 1 each cycle instruction_fetch_en=1, saturating at 16'hFFFF.
REQ-029 load_count SHALL increment by 1 per accepted write, saturating at 16'hFFFF.
REQ-030 boot_err SHALL set on the cycle after boot_wr_valid=1 in RUN or HALTED; it clears only on rst, and the write is dropped (imem_we=0).

Reset
REQ-031 On rst=1, asynchronously: state=IDLE, fetch_count=0, load_count=0, boot_err=0, wdog_timeout=0, watchdog counter=0.
REQ-032 During reset, instruction_fetch_en=0, imem_we=0, boot_wr_ready=1.
REQ-033 Reset mid-LOAD or mid-RUN SHALL abandon the operation; no write issues during reset, and counts are cleared.

Configuration
REQ-034 Macro FETCH_WATCHDOG_EN: when defined, an 8-bit counter SHALL count consecutive RUN cycles with stall_req=1 and clear on any cycle with stall_req=0 or outside RUN.
REQ-035 With FETCH_WATCHDOG_EN defined, when the counter reaches 255 the FSM SHALL go to HALTED next cycle, set sticky wdog_timeout, and clear the counter; halt_req in that cycle has the same effect.
REQ-036 Without FETCH_WATCHDOG_EN, wdog_timeout SHALL be tied to 0 and no counter SHALL exist.

Verification
REQ-037 Reset, 3 writes (addr 0..2, data 16'h1111/2222/3333), boot_done -> imem_we pulses 3 times with matching addr/data, load_count=3, state=RUN.
REQ-038 In RUN, stall_req high for 4 of 10 cycles -> instruction_fetch_en low exactly those 4 cycles, fetch_count=6.
REQ-039 In RUN, boot_wr_valid=1 for one cycle -> imem_we stays 0, boot_wr_ready=0, boot_err=1 next cycle and remains 1.
REQ-040 halt_req in RUN -> HALTED next cycle with fetch_en=0; resume -> RUN; halt_req+resume together in HALTED -> stays HALTED.
REQ-041 With FETCH_WATCHDOG_EN, 255 consecutive stalled RUN cycles -> HALTED and wdog_timeout=1; with 254 stalled cycles then 1 unstalled cycle -> no timeout.
REQ-042 Assert rst mid-LOAD after 2 writes -> state=IDLE, load_count=0 immediately, no imem_we while rst=1.
